// File: rtl/rgb_image_pkg.sv
// Shared types and constants for the RGB frame streamer: FSM states, pixel
// field layout, marker bit positions and the test-pattern ROM helper.
`default_nettype none

package rgb_image_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  localparam int MAX_SCALE_SHIFT = 3;

  // Marker bits travel above the pixel field in each buffer word.
  localparam int MARKER_BITS = 4;
  localparam int MK_EOL      = 0;
  localparam int MK_SOL      = 1;
  localparam int MK_EOF      = 2;
  localparam int MK_SOF      = 3;

  function automatic int pixel_bits(input int channels, input int channel_bits);
    return channels * channel_bits;
  endfunction

  // Channel 0 (red) sits in the LSBs.
  function automatic int chan_lsb(input int ch, input int channel_bits);
    return ch * channel_bits;
  endfunction

  function automatic logic [31:0] rom_channel(input logic [31:0] addr, input int ch,
                                              input logic [7:0] seed);
    return (addr >> (4 * ch)) ^ (32'h5A * 32'(ch + 1)) ^ {24'd0, seed};
  endfunction

endpackage

`default_nettype wire

// File: rtl/rgb_image_rom.sv
// Synchronous image ROM, one-cycle read latency. Behavioural stand-in that
// serves an address-derived test pattern keyed by INIT_FILE.
`default_nettype none

module rgb_image_rom
  import rgb_image_pkg::*;
#(
  parameter string INIT_FILE     = "kodim23.mif",
  parameter int    ADDRESS_WIDTH = 14,
  parameter int    CHANNELS      = 3,
  parameter int    CHANNEL_BITS  = 8
) (
  input  logic                             clk,
  input  logic [ADDRESS_WIDTH-1:0]         addr_i,
  output logic [CHANNELS*CHANNEL_BITS-1:0] data_o
);

  localparam int        PIX_W  = pixel_bits(CHANNELS, CHANNEL_BITS);
  localparam logic [7:0] C_SEED = (INIT_FILE == "") ? 8'h00 : 8'hA5;

  logic [PIX_W-1:0] word_d;
  logic [PIX_W-1:0] data_q;

  always_comb begin
    word_d = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      word_d[chan_lsb(c, CHANNEL_BITS) +: CHANNEL_BITS] =
          CHANNEL_BITS'(rom_channel(32'(addr_i), c, C_SEED));
    end
  end

  always_ff @(posedge clk) begin
    data_q <= word_d;
  end

  assign data_o = data_q;

endmodule

`default_nettype wire

// File: rtl/rgb_pixel_skid.sv
// Two-entry data+marker buffer with valid/ready output; exposes its
// occupancy so the issue logic never overfills it.
`default_nettype none

module rgb_pixel_skid #(
  parameter int WIDTH = 28
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic             out_ready_i,
  output logic             out_valid_o,
  output logic [WIDTH-1:0] out_data_o,
  output logic [1:0]       count_o
);

  logic [WIDTH-1:0] head_q;
  logic [WIDTH-1:0] tail_q;
  logic [1:0]       count_q;
  logic             pop;

  assign out_valid_o = (count_q != 2'd0);
  assign pop         = out_valid_o & out_ready_i;
  assign out_data_o  = head_q;
  assign count_o     = count_q;

  // head_q is the presented beat; it only changes on a pop or an empty fill,
  // which keeps the output stable across stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      case (count_q)
        2'd0: begin
          if (in_valid_i) begin
            head_q  <= in_data_i;
            count_q <= 2'd1;
          end
        end
        2'd1: begin
          if (in_valid_i && pop) begin
            head_q <= in_data_i;
          end else if (in_valid_i) begin
            tail_q  <= in_data_i;
            count_q <= 2'd2;
          end else if (pop) begin
            count_q <= 2'd0;
          end
        end
        2'd2: begin
          if (pop) begin
            head_q <= tail_q;
            if (in_valid_i) begin
              tail_q <= in_data_i;
            end else begin
              count_q <= 2'd1;
            end
          end
        end
        default: count_q <= 2'd0;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/rgb_frame_streamer.sv
// Streams the stored image out of the ROM in raster order with power-of-two
// upscaling, frame/line markers and valid/ready flow control.
`default_nettype none

module rgb_frame_streamer
  import rgb_image_pkg::*;
#(
  parameter string INIT_FILE     = "kodim23.mif",
  parameter int    IMAGE_WIDTH   = 116,
  parameter int    IMAGE_HEIGHT  = 78,
  parameter int    ADDRESS_WIDTH = 14,
  parameter int    CHANNELS      = 3,
  parameter int    CHANNEL_BITS  = 8,
  parameter int    COLUMN_MAJOR  = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [1:0]                       scale_shift,
  output logic                             busy,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [CHANNELS*CHANNEL_BITS-1:0] out_pixel,
  output logic                             out_sof,
  output logic                             out_eof,
  output logic                             out_sol,
  output logic                             out_eol,
  output logic                             frame_done
);

  localparam int PIX_W = pixel_bits(CHANNELS, CHANNEL_BITS);
  localparam int BUF_W = PIX_W + MARKER_BITS;
  localparam int OX_W  = $clog2(IMAGE_WIDTH << MAX_SCALE_SHIFT);
  localparam int OY_W  = $clog2(IMAGE_HEIGHT << MAX_SCALE_SHIFT);

  if (IMAGE_WIDTH * IMAGE_HEIGHT > (1 << ADDRESS_WIDTH)) begin : g_size_check
    $error("rgb_frame_streamer: image does not fit in ADDRESS_WIDTH");
  end

  state_e                   state_q;
  logic                     busy_q;
  logic                     done_q;
  logic [1:0]               shift_q;
  logic [OX_W-1:0]          ox_q;
  logic [OY_W-1:0]          oy_q;
  logic                     rom_vld_q;
  logic [MARKER_BITS-1:0]   mk_q;

  logic [31:0]              ow_last;
  logic [31:0]              oh_last;
  logic [31:0]              sx;
  logic [31:0]              sy;
  logic                     at_eol;
  logic                     at_last_row;
  logic                     pop;
  logic                     issue;
  logic [2:0]               pending;
  logic [1:0]               occ;
  logic [ADDRESS_WIDTH-1:0] rom_addr;
  logic [PIX_W-1:0]         rom_data;
  logic [MARKER_BITS-1:0]   mk_d;
  logic [BUF_W-1:0]         buf_out;

  assign ow_last     = (32'(IMAGE_WIDTH) << shift_q) - 32'd1;
  assign oh_last     = (32'(IMAGE_HEIGHT) << shift_q) - 32'd1;
  assign at_eol      = (32'(ox_q) == ow_last);
  assign at_last_row = (32'(oy_q) == oh_last);
  assign sx          = 32'(ox_q) >> shift_q;
  assign sy          = 32'(oy_q) >> shift_q;

  assign rom_addr = (COLUMN_MAJOR != 0)
                  ? ADDRESS_WIDTH'(sx * 32'(IMAGE_HEIGHT) + sy)
                  : ADDRESS_WIDTH'(sy * 32'(IMAGE_WIDTH) + sx);

  always_comb begin
    mk_d         = '0;
    mk_d[MK_SOF] = (ox_q == '0) && (oy_q == '0);
    mk_d[MK_EOF] = at_eol && at_last_row;
    mk_d[MK_SOL] = (ox_q == '0);
    mk_d[MK_EOL] = at_eol;
  end

  // The beat leaving this edge frees its slot, so it is credited back to
  // sustain one read per cycle while the consumer keeps up.
  assign pop     = out_valid & out_ready;
  assign pending = {1'b0, occ} + {2'b00, rom_vld_q} - {2'b00, pop};
  assign issue   = (state_q == ST_RUN) && (pending < 3'd2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      shift_q   <= 2'd0;
      ox_q      <= '0;
      oy_q      <= '0;
      rom_vld_q <= 1'b0;
      mk_q      <= '0;
    end else begin
      done_q    <= 1'b0;
      rom_vld_q <= issue;
      if (issue) begin
        mk_q <= mk_d;
      end
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            shift_q <= scale_shift;
            ox_q    <= '0;
            oy_q    <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (issue) begin
            if (at_eol) begin
              ox_q <= '0;
              if (at_last_row) begin
                state_q <= ST_FLUSH;
              end else begin
                oy_q <= oy_q + OY_W'(1);
              end
            end else begin
              ox_q <= ox_q + OX_W'(1);
            end
          end
        end
        ST_FLUSH: begin
          if (!rom_vld_q && (occ == {1'b0, pop})) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  rgb_image_rom #(
    .INIT_FILE    (INIT_FILE),
    .ADDRESS_WIDTH(ADDRESS_WIDTH),
    .CHANNELS     (CHANNELS),
    .CHANNEL_BITS (CHANNEL_BITS)
  ) u_rom (
    .clk   (clk),
    .addr_i(rom_addr),
    .data_o(rom_data)
  );

  rgb_pixel_skid #(
    .WIDTH(BUF_W)
  ) u_skid (
    .clk        (clk),
    .rst        (rst),
    .in_valid_i (rom_vld_q),
    .in_data_i  ({mk_q, rom_data}),
    .out_ready_i(out_ready),
    .out_valid_o(out_valid),
    .out_data_o (buf_out),
    .count_o    (occ)
  );

  assign out_pixel  = buf_out[PIX_W-1:0];
  assign out_sof    = buf_out[PIX_W + MK_SOF];
  assign out_eof    = buf_out[PIX_W + MK_EOF];
  assign out_sol    = buf_out[PIX_W + MK_SOL];
  assign out_eol    = buf_out[PIX_W + MK_EOL];
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

`default_nettype wire

// File: tb/tb_rgb_frame_streamer.sv
// Directed bench for rgb_frame_streamer: full frames at scale 0/1, random
// backpressure, ignored mid-frame start, back-to-back, reset mid-frame, row-major.
`default_nettype none

module tb_rgb_frame_streamer;

  localparam int W     = 116;
  localparam int H     = 78;
  localparam int LIMIT = 80000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  scale_shift = 2'd0;
  logic        out_ready = 1'b0;
  logic        busy, out_valid, out_sof, out_eof, out_sol, out_eol, frame_done;
  logic [23:0] out_pixel;
  logic [27:0] dut_beat;

  logic        s_start = 1'b0;
  logic [1:0]  s_scale = 2'd0;
  logic        s_ready = 1'b0;
  logic        s_busy, s_valid, s_sof, s_eof, s_sol, s_eol, s_done;
  logic [23:0] s_pixel;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  assign dut_beat = {out_pixel, out_sof, out_eof, out_sol, out_eol};

  rgb_frame_streamer u_dut (
    .clk(clk), .rst(rst), .start(start), .scale_shift(scale_shift), .busy(busy),
    .out_valid(out_valid), .out_ready(out_ready), .out_pixel(out_pixel),
    .out_sof(out_sof), .out_eof(out_eof), .out_sol(out_sol), .out_eol(out_eol),
    .frame_done(frame_done)
  );

  rgb_frame_streamer #(
    .IMAGE_WIDTH(4), .IMAGE_HEIGHT(3), .COLUMN_MAJOR(0)
  ) u_small (
    .clk(clk), .rst(rst), .start(s_start), .scale_shift(s_scale), .busy(s_busy),
    .out_valid(s_valid), .out_ready(s_ready), .out_pixel(s_pixel),
    .out_sof(s_sof), .out_eof(s_eof), .out_sol(s_sol), .out_eol(s_eol),
    .frame_done(s_done)
  );

  // ROM test pattern: R = a[7:0]^FF, G = a[11:4]^11, B = a[15:8]^AB
  function automatic logic [23:0] rom_word(input int a);
    logic [31:0] v;
    v = a;
    return {v[15:8] ^ 8'hAB, v[11:4] ^ 8'h11, v[7:0] ^ 8'hFF};
  endfunction

  function automatic logic [27:0] exp_beat(input int k, input int s);
    int ow, oh, ox, oy, a;
    ow = W << s;
    oh = H << s;
    ox = k % ow;
    oy = k / ow;
    a  = (ox >> s) * H + (oy >> s);
    return {rom_word(a), (ox == 0 && oy == 0), (ox == ow - 1 && oy == oh - 1),
            (ox == 0), (ox == ow - 1)};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_frame(input int s, input bit rnd, input int stop_beats,
                           input bit mid_start, output int beats, output int cycles);
    logic [28:0] held;
    bit          stalled;
    stalled     = 1'b0;
    held        = '0;
    beats       = 0;
    cycles      = 0;
    start       = 1'b1;
    scale_shift = 2'(s);
    while (1) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (stalled) check("stall_hold", 64'({out_valid, dut_beat}), 64'(held));
      if (out_valid && out_ready) begin
        check("beat", 64'(dut_beat), 64'(exp_beat(beats, s)));
        beats++;
      end
      stalled = out_valid && !out_ready;
      held    = {out_valid, dut_beat};
      @(posedge clk);
      #1;
      cycles++;
      if (cycles == 1) begin
        start = 1'b0;
        check("busy_after_start", 64'(busy), 64'd1);
        check("done_clear_after_start", 64'(frame_done), 64'd0);
      end
      if (mid_start && cycles == 500) begin
        start       = 1'b1;
        scale_shift = 2'd3;
      end
      if (mid_start && cycles == 501) start = 1'b0;
      if (stop_beats > 0 && beats >= stop_beats) break;
      if (frame_done) break;
      if (cycles > LIMIT) begin
        vectors++;
        miscompares++;
        $error("FAIL frame_timeout: observed no frame_done after %0d cycles, expected frame_done", cycles);
        break;
      end
    end
    out_ready = 1'b0;
  endtask

  initial begin
    int beats, cycles, sb, sc;

    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 64'({busy, out_valid, frame_done, out_sof, out_eof, out_sol,
                                out_eol, out_pixel}), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Row-major 4x3 image: beats follow ROM order directly
    s_start = 1'b1;
    s_ready = 1'b1;
    sb = 0;
    sc = 0;
    while (sc < 50) begin
      if (s_valid) begin
        check("small_beat", 64'({s_pixel, s_sof, s_eof, s_sol, s_eol}),
              64'({rom_word(sb), sb == 0, sb == 11, sb % 4 == 0, sb % 4 == 3}));
        sb++;
      end
      @(posedge clk);
      #1;
      sc++;
      if (sc == 1) s_start = 1'b0;
      if (s_done) break;
    end
    check("small_beat_count", 64'(sb), 64'd12);
    check("small_done_cycles", 64'(sc), 64'd15);

    // Scale 0, ready high, stray start pulse mid-frame
    run_frame(0, 1'b0, 0, 1'b1, beats, cycles);
    check("f0_beat_count", 64'(beats), 64'd9048);
    check("f0_done_cycles", 64'(cycles), 64'd9051);
    check("f0_busy_low_at_done", 64'(busy), 64'd0);

    // Second frame launched while frame_done is high, random backpressure
    run_frame(0, 1'b1, 0, 1'b0, beats, cycles);
    check("f1_beat_count", 64'(beats), 64'd9048);
    @(posedge clk);
    #1;
    check("f1_done_single_pulse", 64'({frame_done, busy}), 64'd0);
    repeat (3) @(posedge clk);
    #1;

    // Scale 1
    run_frame(1, 1'b0, 0, 1'b0, beats, cycles);
    check("f2_beat_count", 64'(beats), 64'd36192);
    check("f2_done_cycles", 64'(cycles), 64'd36195);
    repeat (2) @(posedge clk);
    #1;

    // Reset after beat 100
    run_frame(0, 1'b0, 101, 1'b0, beats, cycles);
    check("f3_pre_reset_busy", 64'({busy, out_valid}), 64'b11);
    #2;
    rst = 1'b1;
    #1;
    check("reset_midframe_outputs", 64'({busy, out_valid, frame_done, out_sof, out_eof,
                                         out_sol, out_eol, out_pixel}), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    run_frame(0, 1'b0, 0, 1'b0, beats, cycles);
    check("f4_beat_count", 64'(beats), 64'd9048);
    check("f4_done_cycles", 64'(cycles), 64'd9051);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
